// File: rtl/hahaha.sv
// Single-cycle MIPS-subset datapath: executes the held instruction word on every
// rising clk edge against an internal register file (uu1) and data memory (data_memory).

module hahaha_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr_s,
  input  logic [4:0]  raddr_t,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_s_c,
  output logic [31:0] rdata_t_c
);
  logic [31:0] GPR [0:31];

  // Register 0 is forced to read zero regardless of storage contents.
  assign rdata_s_c = (raddr_s == 5'd0) ? 32'd0 : GPR[raddr_s];
  assign rdata_t_c = (raddr_t == 5'd0) ? 32'd0 : GPR[raddr_t];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) GPR[i] <= 32'd0;
    end else if (wen && (waddr != 5'd0)) begin
      GPR[waddr] <= wdata;
    end
  end
endmodule

module hahaha_dmem #(
  parameter int unsigned DMEM_WORDS = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [$clog2(DMEM_WORDS)-1:0] idx,
  input  logic                          wen,
  input  logic [31:0]                   wdata,
  output logic [31:0]                   rdata_c
);
  logic [31:0] mem [0:DMEM_WORDS-1];

  assign rdata_c = mem[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DMEM_WORDS); i++) mem[i] <= 32'd0;
    end else if (wen) begin
      mem[idx] <= wdata;
    end
  end
endmodule

module hahaha #(
  parameter int unsigned DMEM_WORDS = 256
) (
  input logic        clk,
  input logic        rst_n,
  input logic [31:0] instruction
);
  localparam int unsigned AW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  logic [5:0]    opcode;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    shamt;
  logic [5:0]    funct;
  logic [15:0]   imm;
  logic [31:0]   src_s;
  logic [31:0]   src_t;
  logic [31:0]   imm_sext;
  logic [31:0]   imm_zext;
  logic [AW-1:0] word_idx;
  logic [31:0]   mem_rdata;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          mem_we;

  assign opcode   = instruction[31:26];
  assign rs       = instruction[25:21];
  assign rt       = instruction[20:16];
  assign rd       = instruction[15:11];
  assign shamt    = instruction[10:6];
  assign funct    = instruction[5:0];
  assign imm      = instruction[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'd0, imm};

  // Word index wraps: high address bits and byte offset are discarded.
  assign word_idx = AW'((src_s + imm_sext) >> 2);

  hahaha_regfile uu1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .raddr_s   (rs),
    .raddr_t   (rt),
    .wen       (wr_en),
    .waddr     (wr_addr),
    .wdata     (wr_data),
    .rdata_s_c (src_s),
    .rdata_t_c (src_t)
  );

  hahaha_dmem #(.DMEM_WORDS(DMEM_WORDS)) data_memory (
    .clk     (clk),
    .rst_n   (rst_n),
    .idx     (word_idx),
    .wen     (mem_we),
    .wdata   (src_t),
    .rdata_c (mem_rdata)
  );

  // Decode and execute; unknown opcodes/functs leave every write disabled.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rd;
    wr_data = 32'd0;
    mem_we  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        wr_en = 1'b1;
        case (funct)
          FN_SLL:           wr_data = src_t << shamt;
          FN_SRL:           wr_data = src_t >> shamt;
          FN_SRA:           wr_data = 32'($signed(src_t) >>> shamt);
          FN_SLLV:          wr_data = src_t << src_s[4:0];
          FN_SRLV:          wr_data = src_t >> src_s[4:0];
          FN_SRAV:          wr_data = 32'($signed(src_t) >>> src_s[4:0]);
          FN_ADD, FN_ADDU:  wr_data = src_s + src_t;
          FN_SUB, FN_SUBU:  wr_data = src_s - src_t;
          FN_AND:           wr_data = src_s & src_t;
          FN_OR:            wr_data = src_s | src_t;
          FN_XOR:           wr_data = src_s ^ src_t;
          FN_NOR:           wr_data = ~(src_s | src_t);
          FN_SLT:           wr_data = {31'd0, $signed(src_s) < $signed(src_t)};
          FN_SLTU:          wr_data = {31'd0, src_s < src_t};
          default:          wr_en   = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        wr_en = 1'b1; wr_addr = rt; wr_data = src_s + imm_sext;
      end
      OP_SLTI: begin
        wr_en = 1'b1; wr_addr = rt; wr_data = {31'd0, $signed(src_s) < $signed(imm_sext)};
      end
      OP_SLTIU: begin
        wr_en = 1'b1; wr_addr = rt; wr_data = {31'd0, src_s < imm_sext};
      end
      OP_ANDI: begin
        wr_en = 1'b1; wr_addr = rt; wr_data = src_s & imm_zext;
      end
      OP_ORI: begin
        wr_en = 1'b1; wr_addr = rt; wr_data = src_s | imm_zext;
      end
      OP_XORI: begin
        wr_en = 1'b1; wr_addr = rt; wr_data = src_s ^ imm_zext;
      end
      OP_LUI: begin
        wr_en = 1'b1; wr_addr = rt; wr_data = {imm, 16'd0};
      end
      OP_LW: begin
        wr_en = 1'b1; wr_addr = rt; wr_data = mem_rdata;
      end
      OP_SW: begin
        mem_we = 1'b1;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_hahaha.sv
// Directed bench for hahaha: drives instruction words and checks register file and
// data memory contents hierarchically against hand-computed values.

module tb_hahaha;
  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  int          n_checks;
  int          n_fail;

  hahaha #(.DMEM_WORDS(256)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] s,
                                        input logic [4:0] t, input logic [4:0] d,
                                        input logic [4:0] sh);
    return {6'h00, s, t, d, sh, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  // Present a word at the falling edge, let one rising edge execute it, sample after.
  task automatic exec(input logic [31:0] word);
    @(negedge clk);
    instruction = word;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instruction = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (dut.uu1.GPR[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_gpr[%0d]: got %h expected 00000000", i, dut.uu1.GPR[i]);
      end
    end
    for (int i = 0; i < 256; i += 17) begin
      n_checks++;
      if (dut.data_memory.mem[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_mem[%0d]: got %h expected 00000000", i, dut.data_memory.mem[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lui_hold();
    @(negedge clk);
    instruction = enc_i(6'h0F, 5'd0, 5'd11, 16'd1000);
    repeat (7) @(posedge clk);
    #1;
    n_checks++;
    if (dut.uu1.GPR[11] !== 32'h03E8_0000) begin
      n_fail++; $display("FAIL lui_r11: got %h expected 03e80000", dut.uu1.GPR[11]);
    end
    n_checks++;
    if (dut.uu1.GPR[0] !== 32'd0) begin
      n_fail++; $display("FAIL lui_r0: got %h expected 00000000", dut.uu1.GPR[0]);
    end
    n_checks++;
    if (dut.data_memory.mem[3] !== 32'd0) begin
      n_fail++; $display("FAIL lui_mem3: got %h expected 00000000", dut.data_memory.mem[3]);
    end
  endtask

  task automatic test_load_store();
    exec(enc_i(6'h0D, 5'd0, 5'd1, 16'h1234));
    n_checks++;
    if (dut.uu1.GPR[1] !== 32'h0000_1234) begin
      n_fail++; $display("FAIL ori_r1: got %h expected 00001234", dut.uu1.GPR[1]);
    end
    exec(enc_i(6'h2B, 5'd0, 5'd1, 16'd12));
    n_checks++;
    if (dut.data_memory.mem[3] !== 32'h0000_1234) begin
      n_fail++; $display("FAIL sw_mem3: got %h expected 00001234", dut.data_memory.mem[3]);
    end
    exec(enc_i(6'h08, 5'd0, 5'd2, 16'd2));
    exec(enc_i(6'h23, 5'd2, 5'd14, 16'd10));
    n_checks++;
    if (dut.uu1.GPR[14] !== 32'h0000_1234) begin
      n_fail++; $display("FAIL lw_r14: got %h expected 00001234", dut.uu1.GPR[14]);
    end
  endtask

  task automatic test_compare_shift();
    exec(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFF));
    n_checks++;
    if (dut.uu1.GPR[2] !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL addi_neg_r2: got %h expected ffffffff", dut.uu1.GPR[2]);
    end
    exec(enc_r(6'h2B, 5'd0, 5'd2, 5'd3, 5'd0));
    n_checks++;
    if (dut.uu1.GPR[3] !== 32'd1) begin
      n_fail++; $display("FAIL sltu_r3: got %h expected 00000001", dut.uu1.GPR[3]);
    end
    exec(enc_r(6'h2A, 5'd0, 5'd2, 5'd4, 5'd0));
    n_checks++;
    if (dut.uu1.GPR[4] !== 32'd0) begin
      n_fail++; $display("FAIL slt_r4: got %h expected 00000000", dut.uu1.GPR[4]);
    end
    exec(enc_r(6'h03, 5'd0, 5'd2, 5'd5, 5'd4));
    n_checks++;
    if (dut.uu1.GPR[5] !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL sra_r5: got %h expected ffffffff", dut.uu1.GPR[5]);
    end
    exec(enc_r(6'h02, 5'd0, 5'd2, 5'd6, 5'd28));
    n_checks++;
    if (dut.uu1.GPR[6] !== 32'h0000_000F) begin
      n_fail++; $display("FAIL srl_r6: got %h expected 0000000f", dut.uu1.GPR[6]);
    end
  endtask

  task automatic test_alu_mix();
    exec(enc_r(6'h22, 5'd0, 5'd1, 5'd9, 5'd0));
    n_checks++;
    if (dut.uu1.GPR[9] !== 32'hFFFF_EDCC) begin
      n_fail++; $display("FAIL sub_r9: got %h expected ffffedcc", dut.uu1.GPR[9]);
    end
    exec(enc_r(6'h27, 5'd0, 5'd1, 5'd10, 5'd0));
    n_checks++;
    if (dut.uu1.GPR[10] !== 32'hFFFF_EDCB) begin
      n_fail++; $display("FAIL nor_r10: got %h expected ffffedcb", dut.uu1.GPR[10]);
    end
    exec(enc_i(6'h08, 5'd0, 5'd13, 16'd36));
    exec(enc_r(6'h04, 5'd13, 5'd1, 5'd12, 5'd0));
    n_checks++;
    if (dut.uu1.GPR[12] !== 32'h0001_2340) begin
      n_fail++; $display("FAIL sllv_mask_r12: got %h expected 00012340", dut.uu1.GPR[12]);
    end
    exec(enc_r(6'h07, 5'd13, 5'd9, 5'd15, 5'd0));
    n_checks++;
    if (dut.uu1.GPR[15] !== 32'hFFFF_FEDC) begin
      n_fail++; $display("FAIL srav_r15: got %h expected fffffedc", dut.uu1.GPR[15]);
    end
    exec(enc_i(6'h0B, 5'd1, 5'd16, 16'hFFFF));
    n_checks++;
    if (dut.uu1.GPR[16] !== 32'd1) begin
      n_fail++; $display("FAIL sltiu_r16: got %h expected 00000001", dut.uu1.GPR[16]);
    end
    exec(enc_i(6'h0A, 5'd1, 5'd17, 16'hFFFF));
    n_checks++;
    if (dut.uu1.GPR[17] !== 32'd0) begin
      n_fail++; $display("FAIL slti_r17: got %h expected 00000000", dut.uu1.GPR[17]);
    end
    exec(enc_i(6'h0E, 5'd1, 5'd18, 16'hFFFF));
    n_checks++;
    if (dut.uu1.GPR[18] !== 32'h0000_EDCB) begin
      n_fail++; $display("FAIL xori_r18: got %h expected 0000edcb", dut.uu1.GPR[18]);
    end
    exec(enc_i(6'h0C, 5'd2, 5'd19, 16'h8001));
    n_checks++;
    if (dut.uu1.GPR[19] !== 32'h0000_8001) begin
      n_fail++; $display("FAIL andi_r19: got %h expected 00008001", dut.uu1.GPR[19]);
    end
  endtask

  task automatic test_overflow();
    exec(enc_i(6'h0F, 5'd0, 5'd7, 16'h7FFF));
    exec(enc_i(6'h0D, 5'd7, 5'd7, 16'hFFFF));
    n_checks++;
    if (dut.uu1.GPR[7] !== 32'h7FFF_FFFF) begin
      n_fail++; $display("FAIL lui_ori_r7: got %h expected 7fffffff", dut.uu1.GPR[7]);
    end
    exec(enc_r(6'h20, 5'd7, 5'd7, 5'd8, 5'd0));
    n_checks++;
    if (dut.uu1.GPR[8] !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL add_ovf_r8: got %h expected fffffffe", dut.uu1.GPR[8]);
    end
  endtask

  task automatic test_zero_and_nop();
    exec(enc_i(6'h08, 5'd0, 5'd0, 16'd5));
    n_checks++;
    if (dut.uu1.GPR[0] !== 32'd0) begin
      n_fail++; $display("FAIL r0_write: got %h expected 00000000", dut.uu1.GPR[0]);
    end
    exec(enc_i(6'h3F, 5'd0, 5'd1, 16'd12));
    n_checks++;
    if (dut.uu1.GPR[1] !== 32'h0000_1234) begin
      n_fail++; $display("FAIL undef_op_r1: got %h expected 00001234", dut.uu1.GPR[1]);
    end
    n_checks++;
    if (dut.data_memory.mem[3] !== 32'h0000_1234) begin
      n_fail++; $display("FAIL undef_op_mem3: got %h expected 00001234", dut.data_memory.mem[3]);
    end
    exec(enc_r(6'h01, 5'd1, 5'd1, 5'd20, 5'd0));
    n_checks++;
    if (dut.uu1.GPR[20] !== 32'd0) begin
      n_fail++; $display("FAIL undef_funct_r20: got %h expected 00000000", dut.uu1.GPR[20]);
    end
  endtask

  task automatic test_back_to_back();
    exec(enc_r(6'h21, 5'd1, 5'd1, 5'd1, 5'd0));
    n_checks++;
    if (dut.uu1.GPR[1] !== 32'h0000_2468) begin
      n_fail++; $display("FAIL addu_same_reg_r1: got %h expected 00002468", dut.uu1.GPR[1]);
    end
    exec(enc_i(6'h23, 5'd0, 5'd20, 16'h040E));
    n_checks++;
    if (dut.uu1.GPR[20] !== 32'h0000_1234) begin
      n_fail++; $display("FAIL lw_wrap_r20: got %h expected 00001234", dut.uu1.GPR[20]);
    end
  endtask

  task automatic test_reset_hold();
    @(negedge clk);
    rst_n = 1'b0;
    instruction = enc_i(6'h0D, 5'd0, 5'd21, 16'h0055);
    @(posedge clk);
    #1;
    n_checks++;
    if (dut.uu1.GPR[21] !== 32'd0) begin
      n_fail++; $display("FAIL reset_ignores_edge_r21: got %h expected 00000000", dut.uu1.GPR[21]);
    end
    n_checks++;
    if (dut.uu1.GPR[8] !== 32'd0) begin
      n_fail++; $display("FAIL reset_clears_r8: got %h expected 00000000", dut.uu1.GPR[8]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (dut.uu1.GPR[21] !== 32'h0000_0055) begin
      n_fail++; $display("FAIL first_edge_after_reset_r21: got %h expected 00000055", dut.uu1.GPR[21]);
    end
  endtask

  task automatic test_async_reset();
    exec(enc_i(6'h2B, 5'd0, 5'd21, 16'd0));
    n_checks++;
    if (dut.data_memory.mem[0] !== 32'h0000_0055) begin
      n_fail++; $display("FAIL sw_mem0: got %h expected 00000055", dut.data_memory.mem[0]);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut.uu1.GPR[21] !== 32'd0) begin
      n_fail++; $display("FAIL async_reset_r21: got %h expected 00000000", dut.uu1.GPR[21]);
    end
    n_checks++;
    if (dut.data_memory.mem[0] !== 32'd0) begin
      n_fail++; $display("FAIL async_reset_mem0: got %h expected 00000000", dut.data_memory.mem[0]);
    end
    n_checks++;
    if (dut.data_memory.mem[3] !== 32'd0) begin
      n_fail++; $display("FAIL async_reset_mem3: got %h expected 00000000", dut.data_memory.mem[3]);
    end
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    instruction = 32'd0;
    test_reset();
    test_lui_hold();
    test_load_store();
    test_compare_shift();
    test_alu_mix();
    test_overflow();
    test_zero_and_nop();
    test_back_to_back();
    test_reset_hold();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hahaha.md
HAHAHA -- requirements
Module: hahaha

Interface
REQ-001 SHALL have parameter DMEM_WORDS, default 256, meaning the data-memory depth in 32-bit words (power of two).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port instruction, input, 32 bits: the MIPS-format word executed each rising clk edge; no PC or fetch inside the block.
REQ-005 SHALL have no other ports; state is observed hierarchically.
REQ-006 SHALL place the register file in instance uu1, as array GPR[0:31] of 32-bit words.
REQ-007 SHALL place the data memory in instance data_memory, as array mem[0:DMEM_WORDS-1] of 32-bit words.

Function
REQ-008 SHALL be single-cycle: decode/ALU combinational from instruction; GPR/mem write on the same rising edge, visible immediately after it.
REQ-009 SHALL re-execute the held instruction on every rising edge (no internal sequencing); stable instruction each cycle is the driver's duty.
REQ-010 SHALL decode fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0].
REQ-011 SHALL support R-type (opcode 0x00), result to rd, funct: add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sltu 0x2B, sll 0x00, srl 0x02, sra 0x03, sllv 0x04, srlv 0x06, srav 0x07.
REQ-012 SHALL support I-type, result to rt: addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B (sign-extended imm), andi 0x0C, ori 0x0D, xori 0x0E (zero-extended imm), lui 0x0F (rt = imm<<16, rs ignored).
REQ-013 SHALL support lw 0x23 (rt = mem[word index]) and sw 0x2B (mem[word index] = GPR[rt]), byte address = GPR[rs] + sign-extended imm.
REQ-014 SHALL use word index = address[log2(DMEM_WORDS)+1:2]; upper address bits and address[1:0] ignored (wrap-around, no alignment trap).
REQ-015 SHALL use 32-bit modular arithmetic; add/addi/sub never trap on overflow (same as unsigned forms).
REQ-016 SHALL compute slt/slti as signed and sltu/sltiu as unsigned compares, result 1 or 0.
REQ-017 SHALL mask variable shift amounts to GPR[rs][4:0]; sra/srav shift in the sign bit.
REQ-018 SHALL hold GPR[0] at 0; writes to register 0 discarded, reads of register 0 return 0.
REQ-019 SHALL treat undefined opcode/funct as NOP: no GPR or mem write.
REQ-020 SHALL read both source registers combinationally from pre-edge values (rs = rt = destination uses old value).

Reset
REQ-021 SHALL, while rst_n = 0, immediately (no clock) clear all GPR[0..31] and all mem[] words to 0.
REQ-022 SHALL ignore clk edges while rst_n = 0; first execution on the first rising edge after rst_n goes high.
REQ-023 SHALL abort the write of an edge coinciding with reset assertion; reset wins.

Verification
REQ-024 SHALL pass: reset, then instruction = {0x0F,0,11,1000} held 7 edges -> GPR[11] = 0x03E80000 (65536000), GPR[0] = 0, mem[3] = 0.
REQ-025 SHALL pass: ori r1,r0,0x1234; sw r1,12(r0) -> mem[3] = 0x00001234; then lw r14,10(r2) with r2 = 2 -> GPR[14] = 0x00001234.
REQ-026 SHALL pass: addi r2,r0,-1; sltu r3,r0,r2 -> r3 = 1; slt r4,r0,r2 -> r4 = 0; sra r5,r2,4 -> 0xFFFFFFFF; srl r6,r2,28 -> 0x0000000F.
REQ-027 SHALL pass: lui r7,0x7FFF; ori r7,r7,0xFFFF; add r8,r7,r7 -> r8 = 0xFFFFFFFE, no trap.
REQ-028 SHALL pass: addi r0,r0,5 -> GPR[0] stays 0; undefined opcode 0x3F -> no state change.
REQ-029 SHALL pass: rst_n pulsed low mid-clock-cycle after writes -> GPR and mem read 0 before the next edge.
